pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the 5-stage RV32I pipeline. Drives pc_next into the
//  PC register, which has no enable and resets to 0. Redirects are resolved
//  with priority: trap, then branch, then jump, then stall, then sequential.
//  Also generates IF/ID and ID/EX flush strobes, fetch-valid gating, halt/resume
//  and a redirect performance counter.
// PARAMETERS
//  RESET_VEC     32'h0000_0000  first fetch address after boot; matches PC reset value
//  TRAP_VEC      32'h0000_0100  redirect target on trap_i
//  BOOT_CYCLES   2              cycles held in BOOT after reset release (>=1)
//  FLUSH_CYCLES  2              bubble cycles in FLUSH after any redirect (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   synchronous, active-high
//  pc_i            in   32  current PC (PC register output)
//  stall_i         in   1   load-use hazard: hold PC
//  br_taken_i      in   1   EX-stage branch resolved taken
//  br_target_i     in   32  branch target
//  jmp_i           in   1   EX-stage JAL/JALR
//  jmp_target_i    in   32  jump target
//  trap_i          in   1   ecall/illegal-instr trap request
//  halt_i          in   1   debug halt request
//  resume_i        in   1   leave HALT
//  pc_next_o       out  32  next PC to PC register
//  fetch_valid_o   out  1   fetched instruction is valid (IF/ID capture enable)
//  flush_if_id_o   out  1   squash IF/ID this cycle
//  flush_id_ex_o   out  1   squash ID/EX this cycle
//  misalign_o      out  1   1-cycle pulse: accepted target had bits[1:0]!=0
//  state_o         out  2   BOOT=0 RUN=1 FLUSH=2 HALT=3
//  redirect_cnt_o  out  16  accepted redirects, saturating
// BEHAVIOUR
//  - Reset (registered state): state=BOOT, boot/flush counters loaded, redirect_cnt_o=0.
//    Comb outputs in BOOT: pc_next_o=RESET_VEC, fetch_valid_o=0, flushes=0, misalign_o=0.
//  - redirect = trap_i | br_taken_i | jmp_i. Target is TRAP_VEC if trap_i, else
//    br_target_i if br_taken_i, else jmp_target_i. Target bits[1:0] are forced to 0.
//    misalign_o is asserted in the same cycle if the raw target had bits[1:0]!=0.
//  - pc_next_o, fetch_valid_o, flush_*_o and misalign_o are combinational from state and inputs.
//  - Sequential PC is pc_i+32'd4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
//  - BOOT: all inputs ignored. pc_next_o=RESET_VEC. After BOOT_CYCLES cycles -> RUN.
//  - RUN:
//     - redirect: pc_next_o=target, flush_if_id_o=flush_id_ex_o=1, fetch_valid_o=0,
//       cnt++ -> FLUSH.
//     - else halt_i: pc_next_o=pc_i, fetch_valid_o=0 -> HALT.
//     - else stall_i: pc_next_o=pc_i, fetch_valid_o=1, no flush.
//     - else: pc_next_o=pc_i+4, fetch_valid_o=1.
//  - FLUSH: pc_next_o=pc_i (hold), fetch_valid_o=0, flush_if_id_o=1.
//     - stall_i and halt_i are ignored.
//     - After FLUSH_CYCLES cycles -> RUN.
//     - trap_i only: the redirect is re-taken as in RUN (cnt++), the counter reloads,
//       and the state stays FLUSH. Branch and jump are ignored because they are wrong-path.
//  - HALT: pc_next_o=pc_i, fetch_valid_o=0, no flush.
//     - trap_i: redirect to TRAP_VEC -> FLUSH.
//     - else resume_i -> RUN on the next cycle.
//     - halt_i and resume_i both high: resume wins.
//  - redirect_cnt_o saturates at 16'hFFFF.
//  - Reset asserted mid-operation (any state): next cycle is BOOT with all reset values.
//    Any pending redirect is dropped and not counted.
// TESTING
//  1. Reset 3 cycles, release -> pc_next_o=0 and fetch_valid_o=0 for 2 cycles,
//     then RUN: pc_i=0 gives pc_next_o=4, fetch_valid_o=1.
//  2. RUN pc_i=0x40, br_taken_i=1, br_target_i=0x80 -> pc_next_o=0x80, both flushes=1,
//     cnt=1; FLUSH for 2 cycles; then pc_i=0x80 gives 0x84.
//  3. RUN, trap_i=br_taken_i=jmp_i=1 -> pc_next_o=0x100; stall_i=1 alone at pc_i=0x20
//     -> pc_next_o=0x20, fetch_valid_o=1, no flush.
//  4. jmp_i=1, jmp_target_i=0x203 -> pc_next_o=0x200, misalign_o=1 for one cycle;
//     pc_i=0xFFFF_FFFC sequential -> pc_next_o=0.
//  5. halt_i in RUN -> HALT, pc held 5 cycles; resume_i -> RUN, pc+4 resumes.
//     trap_i in HALT -> pc_next_o=0x100, FLUSH.
//  6. Reset during FLUSH -> state_o=0, cnt=0. Force 65536 redirects -> redirect_cnt_o
//     stays 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect/hazard inputs and next-PC outputs of the PC sequencer
interface pc_sequencer_if;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        trap_i;
  logic        halt_i;
  logic        resume_i;
  logic [31:0] pc_next_o;
  logic        fetch_valid_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        misalign_o;
  logic [1:0]  state_o;
  logic [15:0] redirect_cnt_o;
  modport master (
    output pc_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, trap_i, halt_i, resume_i,
    input  pc_next_o, fetch_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o, state_o, redirect_cnt_o
  );
  modport slave (
    input  pc_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, trap_i, halt_i, resume_i,
    output pc_next_o, fetch_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o, state_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with prioritized redirects, flush bubbles, halt and redirect counter
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          BOOT_CYCLES  = 2,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int MAXC = BOOT_CYCLES > FLUSH_CYCLES ? BOOT_CYCLES : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [15:0]   r_redirect_cnt;
  logic          w_redirect, w_take;
  logic [31:0]   w_tgt_raw;
  assign w_redirect = bus.trap_i | bus.br_taken_i | bus.jmp_i;
  // Outside RUN only a trap is taken, so the same mux yields TRAP_VEC there
  assign w_tgt_raw  = bus.trap_i ? TRAP_VEC : bus.br_taken_i ? bus.br_target_i : bus.jmp_target_i;
  always_comb begin
    w_state_nx         = r_state;
    w_cnt_nx           = r_cnt;
    w_take             = 1'b0;
    bus.pc_next_o      = bus.pc_i;
    bus.fetch_valid_o  = 1'b0;
    bus.flush_if_id_o  = 1'b0;
    bus.flush_id_ex_o  = 1'b0;
    case (r_state)
      BOOT: begin
        bus.pc_next_o = RESET_VEC;
        w_state_nx    = r_cnt == '0 ? RUN : BOOT;
        w_cnt_nx      = r_cnt == '0 ? r_cnt : r_cnt - CW'(1);
      end
      RUN: begin
        w_take            = w_redirect;
        w_state_nx        = !w_redirect && bus.halt_i ? HALT : RUN;
        bus.fetch_valid_o = !w_redirect && !bus.halt_i;
        bus.pc_next_o     = !w_redirect && !bus.halt_i && !bus.stall_i ? bus.pc_i + 32'd4 : bus.pc_i;
      end
      FLUSH: begin
        w_take            = bus.trap_i;
        bus.flush_if_id_o = 1'b1;
        w_state_nx        = r_cnt == '0 ? RUN : FLUSH;
        w_cnt_nx          = r_cnt == '0 ? r_cnt : r_cnt - CW'(1);
      end
      HALT: begin
        w_take     = bus.trap_i;
        w_state_nx = bus.resume_i ? RUN : HALT;
      end
      default: w_state_nx = BOOT;
    endcase
    if (w_take) begin
      bus.pc_next_o     = {w_tgt_raw[31:2], 2'b00};
      bus.fetch_valid_o = 1'b0;
      bus.flush_if_id_o = 1'b1;
      bus.flush_id_ex_o = 1'b1;
      w_state_nx        = FLUSH;
      w_cnt_nx          = CW'(FLUSH_CYCLES - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= BOOT;
      r_cnt          <= CW'(BOOT_CYCLES - 1);
      r_redirect_cnt <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_redirect_cnt <= r_redirect_cnt + 16'(w_take && r_redirect_cnt != 16'hFFFF);
    end
  end
  assign bus.misalign_o     = w_take && w_tgt_raw[1:0] != 2'b00;
  assign bus.state_o        = r_state;
  assign bus.redirect_cnt_o = r_redirect_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: cycle-by-cycle trace table plus redirect-counter saturation sequence
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  // in_f = {rst, stall, br, jmp, trap, halt, resume}; e_f = {fetch_valid, flush_if_id, flush_id_ex, misalign}
  typedef struct {
    logic [6:0]  in_f;
    logic [31:0] pc, bt, jt, e_pc;
    logic [3:0]  e_f;
    logic [1:0]  e_st;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tv[28];
  function automatic vec_t mk(logic [6:0] f, logic [31:0] pc, logic [31:0] bt, logic [31:0] jt,
                              logic [31:0] epc, logic [3:0] ef, logic [1:0] st, logic [15:0] cnt);
    vec_t v;
    v.in_f = f; v.pc = pc; v.bt = bt; v.jt = jt; v.e_pc = epc; v.e_f = ef; v.e_st = st; v.e_cnt = cnt;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    reset = v.in_f[6];
    bus.stall_i = v.in_f[5];
    bus.br_taken_i = v.in_f[4];
    bus.jmp_i = v.in_f[3];
    bus.trap_i = v.in_f[2];
    bus.halt_i = v.in_f[1];
    bus.resume_i = v.in_f[0];
    bus.pc_i = v.pc;
    bus.br_target_i = v.bt;
    bus.jmp_target_i = v.jt;
  endtask
  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%h f=%b st=%0d cnt=%h, want pc=%h f=%b st=%0d cnt=%h", name,
               act[55:24], act[23:20], act[19:18], act[17:2], exp[55:24], exp[23:20], exp[19:18], exp[17:2]);
    end
  endtask
  function automatic logic [55:0] snap();
    return {bus.pc_next_o, bus.fetch_valid_o, bus.flush_if_id_o, bus.flush_id_ex_o, bus.misalign_o,
            bus.state_o, bus.redirect_cnt_o, 2'b00};
  endfunction
  initial begin
    tv[0]  = mk(7'b0000000, 32'h0,        32'h0,   32'h0,   32'h0,   4'b0000, 2'd0, 16'd0);
    tv[1]  = mk(7'b0000100, 32'h0,        32'h0,   32'h0,   32'h0,   4'b0000, 2'd0, 16'd0);
    tv[2]  = mk(7'b0000000, 32'h0,        32'h0,   32'h0,   32'h4,   4'b1000, 2'd1, 16'd0);
    tv[3]  = mk(7'b0010000, 32'h40,       32'h80,  32'h0,   32'h80,  4'b0110, 2'd1, 16'd0);
    tv[4]  = mk(7'b0100010, 32'h80,       32'h0,   32'h0,   32'h80,  4'b0100, 2'd2, 16'd1);
    tv[5]  = mk(7'b0010000, 32'h80,       32'h300, 32'h0,   32'h80,  4'b0100, 2'd2, 16'd1);
    tv[6]  = mk(7'b0000000, 32'h80,       32'h0,   32'h0,   32'h84,  4'b1000, 2'd1, 16'd1);
    tv[7]  = mk(7'b0011100, 32'h84,       32'h44,  32'h48,  32'h100, 4'b0110, 2'd1, 16'd1);
    tv[8]  = mk(7'b0000100, 32'h100,      32'h0,   32'h0,   32'h100, 4'b0110, 2'd2, 16'd2);
    tv[9]  = mk(7'b0000000, 32'h100,      32'h0,   32'h0,   32'h100, 4'b0100, 2'd2, 16'd3);
    tv[10] = mk(7'b0000000, 32'h100,      32'h0,   32'h0,   32'h100, 4'b0100, 2'd2, 16'd3);
    tv[11] = mk(7'b0100000, 32'h20,       32'h0,   32'h0,   32'h20,  4'b1000, 2'd1, 16'd3);
    tv[12] = mk(7'b0001000, 32'h20,       32'h0,   32'h203, 32'h200, 4'b0111, 2'd1, 16'd3);
    tv[13] = mk(7'b0000000, 32'h200,      32'h0,   32'h0,   32'h200, 4'b0100, 2'd2, 16'd4);
    tv[14] = mk(7'b0000000, 32'h200,      32'h0,   32'h0,   32'h200, 4'b0100, 2'd2, 16'd4);
    tv[15] = mk(7'b0000000, 32'hFFFFFFFC, 32'h0,   32'h0,   32'h0,   4'b1000, 2'd1, 16'd4);
    tv[16] = mk(7'b0000010, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd1, 16'd4);
    tv[17] = mk(7'b0000010, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd3, 16'd4);
    tv[18] = mk(7'b0000000, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd3, 16'd4);
    tv[19] = mk(7'b0000000, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd3, 16'd4);
    tv[20] = mk(7'b0000000, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd3, 16'd4);
    tv[21] = mk(7'b0000011, 32'h10,       32'h0,   32'h0,   32'h10,  4'b0000, 2'd3, 16'd4);
    tv[22] = mk(7'b0000000, 32'h10,       32'h0,   32'h0,   32'h14,  4'b1000, 2'd1, 16'd4);
    tv[23] = mk(7'b0000010, 32'h14,       32'h0,   32'h0,   32'h14,  4'b0000, 2'd1, 16'd4);
    tv[24] = mk(7'b0000100, 32'h14,       32'h0,   32'h0,   32'h100, 4'b0110, 2'd3, 16'd4);
    tv[25] = mk(7'b0000000, 32'h100,      32'h0,   32'h0,   32'h100, 4'b0100, 2'd2, 16'd5);
    tv[26] = mk(7'b1000100, 32'h100,      32'h0,   32'h0,   32'h100, 4'b0110, 2'd2, 16'd5);
    tv[27] = mk(7'b0000000, 32'h0,        32'h0,   32'h0,   32'h0,   4'b0000, 2'd0, 16'd0);
    apply(mk(7'b1000000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 16'd0));
    repeat (3) @(posedge clk);
    #1;
    check("in_reset", {32'h0, 4'b0000, bus.state_o, bus.redirect_cnt_o, 2'b00}, {32'h0, 4'b0000, 2'd0, 16'd0, 2'b00});
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      check($sformatf("row%0d", i), snap(), {tv[i].e_pc, tv[i].e_f, tv[i].e_st, tv[i].e_cnt, 2'b00});
    end
    for (int i = 0; i < 10 && bus.state_o != 2'd1; i++) @(negedge clk);
    check("boot_to_run", {54'd0, bus.state_o}, {54'd0, 2'd1});
    @(negedge clk);
    bus.trap_i = 1'b1;
    repeat (65534) @(negedge clk);
    check("cnt_fffe", {40'd0, bus.redirect_cnt_o}, {40'd0, 16'hFFFE});
    @(negedge clk);
    check("cnt_ffff", {40'd0, bus.redirect_cnt_o}, {40'd0, 16'hFFFF});
    repeat (3) @(negedge clk);
    check("cnt_sat", {38'd0, bus.state_o, bus.redirect_cnt_o}, {38'd0, 2'd2, 16'hFFFF});
    bus.trap_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
